receive_engine: RTL and testbench
=================================

# receive_engine

Serial UART receiver that recovers frames on the `Rx` line and delivers parallel bytes plus error status to the processor-side read port. It is the downstream stage of the transmit engine: it decodes exactly the frame formats that engine emits, under the same `eight`/`pen`/`ohel`/`k` configuration. Start-bit detection, mid-bit sampling, parity/framing checks and a one-deep holding register with a ready/read handshake are all internal.

## Interface
Parameters:
- none; all configuration is through ports.

Ports:
- `clk` in 1: system clock; the only clock.
- `rst` in 1: reset, asynchronous, active-low.
- `eight` in 1: 1 = 8 data bits, 0 = 7 data bits.
- `pen` in 1: 1 = parity bit present.
- `ohel` in 1: parity sense; 1 = odd, 0 = even.
- `k` in 19: clocks per bit time; minimum 4.
- `Rx` in 1: asynchronous serial input; idles high.
- `read` in 1: one-cycle pulse; consumes held data and clears status.
- `RxRdy` out 1: held data valid.
- `UART_DS` out 8: received data; bit 7 is 0 in 7-bit mode.
- `PERR` out 1: parity error on the held frame.
- `FERR` out 1: framing error on the held frame (stop bit was 0).
- `OVF` out 1: a frame completed while `RxRdy` was already 1.

## Operation
- Frame format: start(0), then data LSB first (7 or 8 bits), then parity if `pen`, then stop(1).
- N = 7 + `eight` + `pen` + 1 is the number of samples taken after the start bit, range 8..10.
- `Rx` passes through a 2-flop synchronizer before any use.
- State machine:
  - IDLE: synchronized `Rx` = 0 → START, timer cleared.
  - START: timer reaches `k`>>1.
    - `Rx` still 0 → DATA, timer cleared, bit count = 0.
    - `Rx` = 1 → IDLE (false start, nothing reported).
  - DATA: each time the timer reaches `k`-1, shift `Rx` into the MSB of a 10-bit right-shifting register and increment the bit count. When the count reaches N → DONE.
  - DONE (1 cycle): right-justify the frame by shifting right 10-N places, so bit 0 = first data bit.
    - `UART_DS` = `eight` ? bits[7:0] : {0, bits[6:0]}.
    - Parity bit = bit N-2. Stop bit = bit N-1.
    - `PERR` = `pen` & (XOR(data) ^ parity ^ `ohel`) ≠ 0.
    - `FERR` = ~stop.
    - `OVF` = `RxRdy` (value before this update).
    - `RxRdy` ← 1.
    - Next state: stop = 1 → IDLE; stop = 0 → BREAK.
  - BREAK: wait for synchronized `Rx` = 1, then → IDLE. Prevents retriggering on a held-low line.
- `read` clears `RxRdy`, `PERR`, `FERR` and `OVF`; `UART_DS` holds its value.
- `read` in the same cycle as DONE: the DONE update wins and `OVF` = 0.
- Configuration inputs must be stable while not in IDLE; changing them mid-frame gives undefined data but must not hang the FSM.

## Timing
- Reset values: `RxRdy`=0, `UART_DS`=0x00, `PERR`=`FERR`=`OVF`=0. State IDLE, synchronizer flops at 1, timer and shift register cleared.
- A reset asserted mid-frame aborts the frame immediately; no partial data or status is reported.
- Synchronizer latency: 2 clocks.
- The start bit is confirmed (k>>1)+1 clocks after IDLE sees 0.
- Data samples fall every k clocks after start confirmation, at bit centres.
- `RxRdy` rises 1 clock after the stop sample. Total ≈ 2 + (k>>1) + N·k + 2 clocks from the `Rx` falling edge.
- Return to IDLE happens mid-stop-bit, so back-to-back frames with one stop bit are received without loss.
- Timer width is 19 bits; comparisons are unsigned; the timer never wraps because it is cleared on every match.

## Structure
- Shared package `uart_pkg`:
  - FSM state enum (IDLE, START, DATA, DONE, BREAK).
  - Frame-length function N(`eight`, `pen`).
  - Parity function (data, `eight`, `ohel`).
- Sub-module `rx_bit_timer`:
  - 19-bit counter with clear, a half-bit compare (`k`>>1) and a full-bit compare (`k`-1).
  - Outputs `half_tick` and `bit_tick`.
- Synchronizer, FSM, shift register and holding register live in `receive_engine`.

## Test plan
- 8N1, k=109, send 0xA5 → `RxRdy`=1 with `UART_DS`=0xA5 and `PERR`=`FERR`=`OVF`=0. Pulse `read` → `RxRdy`=0 and `UART_DS` still 0xA5.
- 7E1 (`eight`=0, `pen`=1, `ohel`=0): send 0x25 with parity 1 → `UART_DS`=0x25, `PERR`=0. Repeat with parity 0 → `PERR`=1.
- 8O1 (`ohel`=1): send 0xA5 with parity 1 → `PERR`=0. Send stop bit 0 → `FERR`=1; hold `Rx` low 5k → no new frame; release → next 0x3C received.
- Glitch: `Rx` low for 20 clocks at k=109 → no `RxRdy`, state back in IDLE.
- Overrun: two back-to-back 0x11 then 0x22 frames with no `read` → `UART_DS`=0x22, `OVF`=1. `read` on the completion cycle of a third frame → `OVF`=0 and `RxRdy`=1.
- Reset (`rst`=0) in the middle of the data bits → all outputs return to reset values immediately; the following clean frame 0x5A is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART receive types and helpers: FSM states, frame length and parity.
// Combinational helpers only; no latency or flow control of their own.
package uart_pkg;

    localparam int TIMER_W = 19;
    localparam int FRAME_W = 10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_DONE,
        ST_BREAK
    } rx_state_t;

    typedef struct packed {
        logic perr;
        logic ferr;
        logic ovf;
    } rx_status_t;

    // Samples taken after the start bit: data bits, optional parity, stop.
    function automatic logic [3:0] frame_len(input logic eight, input logic pen);
        return 4'd8 + {3'b000, eight} + {3'b000, pen};
    endfunction

    // Parity bit the transmitter would have sent for this data word.
    function automatic logic parity_bit(input logic [7:0] data, input logic eight,
                                        input logic ohel);
        return (^data[6:0]) ^ (eight & data[7]) ^ ohel;
    endfunction

endpackage

// File: rtl/rx_bit_timer.sv
// Free-running bit-time counter with clear; flags half-bit and full-bit points.
// Ticks are combinational from the counter; no backpressure.
module rx_bit_timer
    import uart_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic [TIMER_W-1:0] k,
    output logic               half_tick,
    output logic               bit_tick
);

    logic [TIMER_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Greater-or-equal so a k change mid-frame can never leave the counter
    // running past the match point.
    assign half_tick = (cnt >= (k >> 1));
    assign bit_tick  = (cnt >= (k - 1'b1));

endmodule

// File: rtl/receive_engine.sv
// UART receiver: start detect, mid-bit sampling, parity/framing check, 1-deep hold.
// RxRdy rises 1 clock after the stop sample; unread data is overwritten and flagged via OVF.
module receive_engine
    import uart_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               eight,
    input  logic               pen,
    input  logic               ohel,
    input  logic [TIMER_W-1:0] k,
    input  logic               Rx,
    input  logic               read,
    output logic               RxRdy,
    output logic [7:0]         UART_DS,
    output logic               PERR,
    output logic               FERR,
    output logic               OVF
);

    rx_state_t          state, state_nxt;
    logic               rx_meta, rx_sync;
    logic [3:0]         bit_cnt, bit_cnt_nxt;
    logic [FRAME_W-1:0] shreg;
    logic               shift_en;
    logic               timer_clr;
    logic               half_tick, bit_tick;
    logic [3:0]         n_len;
    logic [FRAME_W-1:0] frame;
    logic [7:0]         data_w;
    logic               par_rx, stop_rx;
    rx_status_t         status_q;

    // Synchronizer idles high so reset does not look like a start bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= Rx;
            rx_sync <= rx_meta;
        end
    end

    rx_bit_timer u_timer (
        .clk       (clk),
        .rst       (rst),
        .clr       (timer_clr),
        .k         (k),
        .half_tick (half_tick),
        .bit_tick  (bit_tick)
    );

    assign n_len   = frame_len(eight, pen);
    assign frame   = shreg >> (4'd10 - n_len);
    assign data_w  = eight ? frame[7:0] : {1'b0, frame[6:0]};
    assign par_rx  = frame[n_len - 4'd2];
    assign stop_rx = frame[n_len - 4'd1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
            shreg   <= '0;
        end else begin
            state   <= state_nxt;
            bit_cnt <= bit_cnt_nxt;
            if (shift_en) begin
                shreg <= {rx_sync, shreg[FRAME_W-1:1]};
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        timer_clr   = 1'b0;
        shift_en    = 1'b0;
        case (state)
            ST_IDLE: begin
                timer_clr = 1'b1;
                if (!rx_sync) begin
                    state_nxt = ST_START;
                end
            end
            ST_START: begin
                if (half_tick) begin
                    timer_clr   = 1'b1;
                    bit_cnt_nxt = '0;
                    state_nxt   = rx_sync ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_tick) begin
                    timer_clr   = 1'b1;
                    shift_en    = 1'b1;
                    bit_cnt_nxt = bit_cnt + 4'd1;
                    if ((bit_cnt + 4'd1) >= n_len) begin
                        state_nxt = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                timer_clr = 1'b1;
                state_nxt = stop_rx ? ST_IDLE : ST_BREAK;
            end
            ST_BREAK: begin
                // A low stop bit may be a held break; wait for the line to rise.
                timer_clr = 1'b1;
                if (rx_sync) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                timer_clr = 1'b1;
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Frame completion takes priority over a read in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            RxRdy    <= 1'b0;
            UART_DS  <= '0;
            status_q <= '0;
        end else if (state == ST_DONE) begin
            RxRdy         <= 1'b1;
            UART_DS       <= data_w;
            status_q.perr <= pen & (par_rx ^ parity_bit(data_w, eight, ohel));
            status_q.ferr <= ~stop_rx;
            status_q.ovf  <= RxRdy & ~read;
        end else if (read) begin
            RxRdy    <= 1'b0;
            status_q <= '0;
        end
    end

    assign PERR = status_q.perr;
    assign FERR = status_q.ferr;
    assign OVF  = status_q.ovf;

endmodule

// File: tb/tb_receive_engine.sv
// Self-checking bench for receive_engine: directed scenarios plus randomized frames
// checked against an ones-counting reference model of the UART frame rules.
module tb_receive_engine;

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic        eight = 1'b1;
    logic        pen   = 1'b0;
    logic        ohel  = 1'b0;
    logic [18:0] k     = 19'd109;
    logic        Rx    = 1'b1;
    logic        read  = 1'b0;
    logic        RxRdy;
    logic [7:0]  UART_DS;
    logic        PERR, FERR, OVF;

    int checks = 0;
    int errors = 0;
    int lat    = 0;
    logic [11:0] got, want;

    receive_engine dut (
        .clk     (clk),
        .rst     (rst),
        .eight   (eight),
        .pen     (pen),
        .ohel    (ohel),
        .k       (k),
        .Rx      (Rx),
        .read    (read),
        .RxRdy   (RxRdy),
        .UART_DS (UART_DS),
        .PERR    (PERR),
        .FERR    (FERR),
        .OVF     (OVF)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [7:0] mask_data(input logic [7:0] d);
        return eight ? d : {1'b0, d[6:0]};
    endfunction

    function automatic logic good_par(input logic [7:0] d);
        int ones;
        ones = $countones(mask_data(d));
        return ((ones % 2) == 1) ^ ohel;
    endfunction

    function automatic logic exp_perr(input logic [7:0] d, input logic par);
        int ones;
        ones = $countones(mask_data(d)) + (par ? 1 : 0);
        return pen && ((ones % 2) != (ohel ? 1 : 0));
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
        Rx = 1'b0;
        repeat (k) @(negedge clk);
        for (int i = 0; i < (eight ? 8 : 7); i++) begin
            Rx = d[i];
            repeat (k) @(negedge clk);
        end
        if (pen) begin
            Rx = par;
            repeat (k) @(negedge clk);
        end
        Rx = stop;
        repeat (k) @(negedge clk);
    endtask

    task automatic idle(input int n);
        Rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_read();
        read = 1'b1;
        @(negedge clk);
        read = 1'b0;
    endtask

    task automatic wait_rdy();
        int n;
        n = 0;
        while (!RxRdy && n < 12 * int'(k) + 50) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic set_cfg(input logic e, input logic p, input logic o, input int kk);
        eight = e;
        pen   = p;
        ohel  = o;
        k     = 19'(kk);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        got = {RxRdy, UART_DS, PERR, FERR, OVF};
        checks++;
        if (got !== 12'h000) begin
            errors++;
            $display("FAIL reset_values: {rdy,ds,perr,ferr,ovf} got %b want %b", got, 12'h000);
        end
        rst = 1'b1;
        idle(5);
    endtask

    task automatic test_8n1();
        int nominal;
        set_cfg(1'b1, 1'b0, 1'b0, 109);
        fork
            send_frame(8'hA5, 1'b0, 1'b1);
            begin
                lat = 0;
                while (!RxRdy && lat < 2000) begin
                    @(negedge clk);
                    lat++;
                end
            end
        join
        got  = {RxRdy, UART_DS, PERR, FERR, OVF};
        want = {1'b1, 8'hA5, 3'b000};
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL 8n1_frame: {rdy,ds,perr,ferr,ovf} got %b want %b", got, want);
        end
        nominal = 4 + (109 >> 1) + 9 * 109;
        checks++;
        if (lat < nominal - 2 || lat > nominal + 2) begin
            errors++;
            $display("FAIL 8n1_latency: got %0d clocks want %0d +/- 2", lat, nominal);
        end
        do_read();
        got  = {RxRdy, UART_DS, PERR, FERR, OVF};
        want = {1'b0, 8'hA5, 3'b000};
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL 8n1_read: {rdy,ds,perr,ferr,ovf} got %b want %b", got, want);
        end
        idle(20);
    endtask

    task automatic test_7e1();
        set_cfg(1'b0, 1'b1, 1'b0, 109);
        send_frame(8'h25, 1'b1, 1'b1);
        wait_rdy();
        got  = {RxRdy, UART_DS, PERR, FERR, OVF};
        want = {1'b1, 8'h25, 3'b000};
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL 7e1_good_parity: {rdy,ds,perr,ferr,ovf} got %b want %b", got, want);
        end
        do_read();
        idle(20);
        send_frame(8'h25, 1'b0, 1'b1);
        wait_rdy();
        got  = {RxRdy, UART_DS, PERR, FERR, OVF};
        want = {1'b1, 8'h25, 3'b100};
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL 7e1_bad_parity: {rdy,ds,perr,ferr,ovf} got %b want %b", got, want);
        end
        do_read();
        got  = {RxRdy, UART_DS, PERR, FERR, OVF};
        want = {1'b0, 8'h25, 3'b000};
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL 7e1_read_clears: {rdy,ds,perr,ferr,ovf} got %b want %b", got, want);
        end
        idle(20);
    endtask

    task automatic test_8o1_break();
        set_cfg(1'b1, 1'b1, 1'b1, 109);
        send_frame(8'hA5, 1'b1, 1'b1);
        wait_rdy();
        got  = {RxRdy, UART_DS, PERR, FERR, OVF};
        want = {1'b1, 8'hA5, 3'b000};
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL 8o1_frame: {rdy,ds,perr,ferr,ovf} got %b want %b", got, want);
        end
        do_read();
        idle(20);
        send_frame(8'h81, good_par(8'h81), 1'b0);
        wait_rdy();
        got  = {RxRdy, UART_DS, PERR, FERR, OVF};
        want = {1'b1, 8'h81, 3'b010};
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL 8o1_framing: {rdy,ds,perr,ferr,ovf} got %b want %b", got, want);
        end
        do_read();
        Rx = 1'b0;
        repeat (5 * int'(k)) @(negedge clk);
        checks++;
        if (RxRdy !== 1'b0) begin
            errors++;
            $display("FAIL break_no_retrigger: RxRdy got %b want 0", RxRdy);
        end
        idle(20);
        send_frame(8'h3C, good_par(8'h3C), 1'b1);
        wait_rdy();
        got  = {RxRdy, UART_DS, PERR, FERR, OVF};
        want = {1'b1, 8'h3C, 3'b000};
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL after_break: {rdy,ds,perr,ferr,ovf} got %b want %b", got, want);
        end
        do_read();
        idle(20);
    endtask

    task automatic test_glitch();
        set_cfg(1'b1, 1'b0, 1'b0, 109);
        Rx = 1'b0;
        repeat (20) @(negedge clk);
        idle(300);
        checks++;
        if (RxRdy !== 1'b0) begin
            errors++;
            $display("FAIL glitch_ignored: RxRdy got %b want 0", RxRdy);
        end
        send_frame(8'h96, 1'b0, 1'b1);
        wait_rdy();
        got  = {RxRdy, UART_DS, PERR, FERR, OVF};
        want = {1'b1, 8'h96, 3'b000};
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL after_glitch: {rdy,ds,perr,ferr,ovf} got %b want %b", got, want);
        end
        do_read();
        idle(20);
    endtask

    task automatic test_back_to_back();
        set_cfg(1'b1, 1'b0, 1'b0, 109);
        send_frame(8'h11, 1'b0, 1'b1);
        checks++;
        if ({RxRdy, UART_DS} !== {1'b1, 8'h11}) begin
            errors++;
            $display("FAIL b2b_first: {rdy,ds} got %b_%h want 1_11", RxRdy, UART_DS);
        end
        send_frame(8'h22, 1'b0, 1'b1);
        wait_rdy();
        got  = {RxRdy, UART_DS, PERR, FERR, OVF};
        want = {1'b1, 8'h22, 3'b001};
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL b2b_overrun: {rdy,ds,perr,ferr,ovf} got %b want %b", got, want);
        end
        idle(20);
        fork
            send_frame(8'h33, 1'b0, 1'b1);
            begin
                repeat (lat - 1) @(negedge clk);
                read = 1'b1;
                @(negedge clk);
                read = 1'b0;
                got  = {RxRdy, UART_DS, PERR, FERR, OVF};
                want = {1'b1, 8'h33, 3'b000};
                checks++;
                if (got !== want) begin
                    errors++;
                    $display("FAIL read_on_done: {rdy,ds,perr,ferr,ovf} got %b want %b", got, want);
                end
            end
        join
        do_read();
        idle(20);
    endtask

    task automatic test_reset_mid();
        set_cfg(1'b1, 1'b0, 1'b0, 109);
        send_frame(8'h77, 1'b0, 1'b1);
        wait_rdy();
        idle(10);
        fork
            send_frame(8'hC3, 1'b0, 1'b1);
            begin
                repeat (4 * int'(k)) @(negedge clk);
                rst = 1'b0;
                #1;
                got = {RxRdy, UART_DS, PERR, FERR, OVF};
                checks++;
                if (got !== 12'h000) begin
                    errors++;
                    $display("FAIL reset_mid_frame: {rdy,ds,perr,ferr,ovf} got %b want %b", got, 12'h000);
                end
            end
        join
        rst = 1'b1;
        idle(20);
        checks++;
        if (RxRdy !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_partial: RxRdy got %b want 0", RxRdy);
        end
        send_frame(8'h5A, 1'b0, 1'b1);
        wait_rdy();
        got  = {RxRdy, UART_DS, PERR, FERR, OVF};
        want = {1'b1, 8'h5A, 3'b000};
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL after_reset: {rdy,ds,perr,ferr,ovf} got %b want %b", got, want);
        end
        do_read();
        idle(20);
    endtask

    task automatic test_random();
        logic [7:0] d;
        logic       par, stop;
        for (int it = 0; it < 16; it++) begin
            set_cfg(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), int'($urandom_range(4, 40)));
            d    = 8'($urandom);
            par  = ($urandom_range(0, 3) == 0) ? ~good_par(d) : good_par(d);
            stop = ($urandom_range(0, 4) != 0);
            send_frame(d, par, stop);
            wait_rdy();
            got  = {RxRdy, UART_DS, PERR, FERR, OVF};
            want = {1'b1, mask_data(d), exp_perr(d, par), ~stop, 1'b0};
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL random_%0d (e=%b p=%b o=%b k=%0d): {rdy,ds,perr,ferr,ovf} got %b want %b",
                         it, eight, pen, ohel, k, got, want);
            end
            do_read();
            checks++;
            if ({RxRdy, PERR, FERR, OVF} !== 4'b0000) begin
                errors++;
                $display("FAIL random_read_%0d: {rdy,perr,ferr,ovf} got %b want 0000",
                         it, {RxRdy, PERR, FERR, OVF});
            end
            idle(2 * int'(k) + 8);
        end
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_7e1();
        test_8o1_break();
        test_glitch();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
